// File: rtl/reduce_reg_bank.sv
// Multi-channel bank of reduction flags: each channel reduces a WIDTH-bit slice
// to one bit (AND/OR/XOR), carries it through a fixed-latency pipeline into a
// per-channel output register with sync clear/set, and counts output rises.
module reduce_reg_bank #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned PIPE_STAGES = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                        clk,
   input  logic                        areset_n,
   input  logic                        in_valid,
   input  logic [1:0]                  mode,
   input  logic [CHANNELS*WIDTH-1:0]   data_in,
   input  logic [CHANNELS-1:0]         ch_en,
   input  logic [CHANNELS-1:0]         sclr,
   input  logic [CHANNELS-1:0]         sset,
   output logic [CHANNELS-1:0]         data_out,
   output logic [CHANNELS-1:0]         out_valid,
   output logic [CHANNELS*CNT_W-1:0]   rise_cnt
);

   // Stage-0 register plus PIPE_STAGES extra stages ahead of the output register.
   localparam int unsigned DEPTH = PIPE_STAGES + 1;

   localparam logic [1:0] MODE_AND  = 2'b00;
   localparam logic [1:0] MODE_OR   = 2'b01;
   localparam logic [1:0] MODE_XOR  = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CHANNELS-1:0]              s0_v_c;
   logic [CHANNELS-1:0]              s0_r_c;

   logic [DEPTH-1:0][CHANNELS-1:0]   pipe_v_q;
   logic [DEPTH-1:0][CHANNELS-1:0]   pipe_r_q;

   logic [CHANNELS-1:0]              arr_v_c;
   logic [CHANNELS-1:0]              arr_r_c;

   logic [CHANNELS-1:0]              dout_d,  dout_q;
   logic [CHANNELS-1:0]              ov_d,    ov_q;
   logic [CHANNELS-1:0][CNT_W-1:0]   cnt_d,   cnt_q;

   // Per-channel qualification and same-cycle reduction of the input slice.
   always_comb begin
      s0_v_c = '0;
      s0_r_c = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         s0_v_c[i] = in_valid & ch_en[i] & (mode != MODE_HOLD);
         unique case (mode)
            MODE_AND: s0_r_c[i] = &data_in[i*WIDTH +: WIDTH];
            MODE_OR:  s0_r_c[i] = |data_in[i*WIDTH +: WIDTH];
            MODE_XOR: s0_r_c[i] = ^data_in[i*WIDTH +: WIDTH];
            default:  s0_r_c[i] = 1'b0;
         endcase
      end
   end

   // Free-running pipeline; HOLD only injects bubbles, reset flushes everything.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         pipe_v_q <= '0;
         pipe_r_q <= '0;
      end else begin
         pipe_v_q[0] <= s0_v_c;
         pipe_r_q[0] <= s0_r_c;
         for (int k = 1; k < int'(DEPTH); k++) begin
            pipe_v_q[k] <= pipe_v_q[k-1];
            pipe_r_q[k] <= pipe_r_q[k-1];
         end
      end
   end

   assign arr_v_c = pipe_v_q[DEPTH-1];
   assign arr_r_c = pipe_r_q[DEPTH-1];

   // Output register priority (clear > set > arrival > hold) and rise counting.
   always_comb begin
      dout_d = dout_q;
      ov_d   = '0;
      cnt_d  = cnt_q;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (sclr[i]) begin
            dout_d[i] = 1'b0;
            cnt_d[i]  = '0;
         end else begin
            if (sset[i]) begin
               dout_d[i] = 1'b1;
            end else if (arr_v_c[i]) begin
               dout_d[i] = arr_r_c[i];
               ov_d[i]   = 1'b1;
            end
            if (!dout_q[i] && dout_d[i] && (cnt_q[i] != CNT_MAX)) begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Output state registers.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         dout_q <= '0;
         ov_q   <= '0;
         cnt_q  <= '0;
      end else begin
         dout_q <= dout_d;
         ov_q   <= ov_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data_out  = dout_q;
   assign out_valid = ov_q;
   assign rise_cnt  = cnt_q;

endmodule

// File: doc/reduce_reg_bank.md
Name: reduce_reg_bank

Overview:
- Parametrised multi-channel bank of reduction registers with per-channel clock enable, synchronous clear and synchronous set.
- Each channel reduces a WIDTH-bit slice to 1 bit (AND/OR/XOR/hold), passes it through an optional pipeline and loads it into an output register.
- A saturating counter per channel records rising edges of that output.
- Used as a status/flag-collection block. All channels share one clock and one async reset, so the whole bank packs into a single control set.

Parameters:
- CHANNELS, 4: number of independent channels.
- WIDTH, 6: input bits per channel reduced to one output bit (>=2).
- PIPE_STAGES, 1: registered stages between the reduction and the output register (0..3).
- CNT_W, 4: rising-edge counter width per channel (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- areset_n  in  1  asynchronous active-low reset; assert asynchronously, deassert synchronously upstream.
- in_valid  in  1  data_in/mode sample qualifier.
- mode  in  2  00=AND, 01=OR, 10=XOR, 11=HOLD (no load).
- data_in  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- ch_en  in  CHANNELS  per-channel clock enable at the pipeline input.
- sclr  in  CHANNELS  per-channel synchronous clear of the output register and counter.
- sset  in  CHANNELS  per-channel synchronous set of the output register.
- data_out  out  CHANNELS  registered per-channel result.
- out_valid  out  CHANNELS  1-cycle pulse: channel output register loaded from the pipeline.
- rise_cnt  out  CHANNELS*CNT_W  per-channel saturating count of data_out 0->1 transitions.

Behaviour:
- Reset (areset_n=0): data_out, out_valid, rise_cnt, all pipeline data and valid bits go to 0 immediately, independent of clk.
- Reset mid-operation flushes the pipeline; nothing in flight emerges after release.
- Input qualification: stage-0 valid for channel i = in_valid & ch_en[i] & (mode!=11).
- Reduction result r_i = AND/OR/XOR of the channel slice per mode, computed from the same-cycle inputs.
- Pipeline: each stage carries {valid_i, r_i} per channel unconditionally. No back-pressure; the pipeline always advances.
- PIPE_STAGES=0: the output register loads directly from the stage-0 result.
- Latency: a qualified sample at edge N updates data_out and pulses out_valid at edge N+1+PIPE_STAGES.
- Output register priority per channel, evaluated each edge:
  1. sclr[i]: data_out=0, out_valid=0, rise_cnt=0.
  2. sset[i]: data_out=1, out_valid=0.
  3. Pipeline valid at the output: data_out=r_i, out_valid=1.
  4. Otherwise: hold, out_valid=0.
- sclr/sset act on the output register only and are not pipelined. In-flight pipeline data still arrives later and loads normally.
- Pipeline data arriving in the same cycle as sclr/sset is discarded for that channel.
- rise_cnt[i]:
  - Increments by 1 on any edge where data_out[i] goes 0->1, whether from sset or from data.
  - Saturates at 2^CNT_W-1; further rises leave it unchanged.
  - sclr clears it and suppresses any increment in that cycle.
- Channels are fully independent; simultaneous sclr on one channel and data load on another both take effect.
- HOLD mode still lets the pipeline advance; it only injects invalid bubbles.

Test Plan:
- Reset: drive activity, drop areset_n between edges -> all outputs 0 at once. After release with PIPE_STAGES=2, a sample injected 1 cycle before reset never produces out_valid.
- AND latency: PIPE_STAGES=1, ch0 data=6'h3F, mode=00, ch_en=1 at edge 0 -> data_out[0]=1 and out_valid[0]=1 at edge 2 only. 6'h3E instead -> 0.
- Modes: ch1 data=6'b000101. Mode 01 -> 1. Mode 10 -> 0. Mode 11 -> no out_valid, data_out holds.
- Priority: sclr[2] and sset[2] together with a valid arrival of 1 -> data_out[2]=0, rise_cnt[2]=0, out_valid[2]=0. Next cycle with sset only -> data_out=1, rise_cnt=1.
- Saturation: CNT_W=2, toggle ch3 output 0->1 five times via sset/sclr-free data loads -> rise_cnt[3] reads 1,2,3,3,3.
- Enable isolation: ch_en=4'b0101, all channels 6'h3F, mode=00 -> only ch0 and ch2 pulse out_valid; ch1 and ch3 hold 0.
